// File: rtl/geofence_poly.sv
`default_nettype none
// ============================================================================
//  Module   : geofence_poly
//  Purpose  : Point-in-convex-polygon engine. Per job it accepts one test
//             point P followed by N_VERT vertices in any order, bubble-sorts
//             vertices 1..N_VERT-1 counter-clockwise about vertex 0 using
//             cross products, then tests P against every edge and reports
//             inside/outside plus an on-boundary flag.
//  Revision : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  rising-edge clock
//    reset      in   1  asynchronous active-low reset
//    in_valid   in   1  X/Y beat is valid
//    in_ready   out  1  block can accept a beat (IDLE/LOAD only)
//    X, Y       in   W  unsigned coordinates of the current beat
//    valid      out  1  one-cycle result strobe
//    is_inside  out  1  result, qualified by valid, held until next result
//    on_edge    out  1  P lies on the polygon boundary, qualified by valid
// ============================================================================
module geofence_poly #(
  parameter int N_VERT       = 6,
  parameter int W            = 10,
  parameter bit INCLUDE_EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         valid,
  output logic         is_inside,
  output logic         on_edge
);

  localparam int IW = $clog2(N_VERT);
  localparam int CW = 2*W + 3;
  localparam logic [IW-1:0] LAST_V = IW'(N_VERT - 1);
  localparam logic [IW-1:0] LAST_J = IW'(N_VERT - 2);
  localparam logic [IW-1:0] LAST_P = IW'(N_VERT - 3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SORT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   px_q, px_d, py_q, py_d;
  logic [W-1:0]   vx_q [N_VERT];
  logic [W-1:0]   vy_q [N_VERT];
  logic [W-1:0]   vx_d [N_VERT];
  logic [W-1:0]   vy_d [N_VERT];
  // idx is the load counter in LOAD, position j in SORT and edge k in CHECK
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  pass_q, pass_d;
  logic           any_neg_q, any_neg_d;
  logic           any_zero_q, any_zero_d;
  logic           valid_q, valid_d;
  logic           inside_q, inside_d;
  logic           onedge_q, onedge_d;
  logic           w_ready;

  // Signed difference a-b of two unsigned coordinates, exact in W+1 bits.
  function automatic logic signed [W:0] sdiff(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // cross(a, b) = ax*by - ay*bx with full precision.
  function automatic logic signed [CW-1:0] cross2(
    input logic signed [W:0] ax, input logic signed [W:0] ay,
    input logic signed [W:0] bx, input logic signed [W:0] by);
    logic signed [2*W+1:0] p1;
    logic signed [2*W+1:0] p2;
    p1 = $signed({{(W+1){ax[W]}}, ax}) * $signed({{(W+1){by[W]}}, by});
    p2 = $signed({{(W+1){ay[W]}}, ay}) * $signed({{(W+1){bx[W]}}, bx});
    return $signed({p1[2*W+1], p1}) - $signed({p2[2*W+1], p2});
  endfunction

  // --------------------------------------------------------------------------
  // Shared cross-product datapath. Both phases evaluate cross(A-O, B-O):
  //   SORT : O = V0,   A = V[j],   B = V[j+1]
  //   CHECK: O = V[k], A = V[k+1], B = P
  // idx+1 wraps to 0 only at k = N_VERT-1 (closing edge); in SORT j never
  // exceeds N_VERT-2 so the wrap is never taken there.
  // --------------------------------------------------------------------------
  logic [IW-1:0]        w_next;
  logic [W-1:0]         w_ox, w_oy, w_ax, w_ay, w_bx, w_by;
  logic signed [CW-1:0] w_cross;
  logic                 w_neg, w_zero;
  logic                 w_sort;

  assign w_sort = (state_q == S_SORT);
  assign w_next = (idx_q == LAST_V) ? '0 : idx_q + IW'(1);
  assign w_ox   = w_sort ? vx_q[0]      : vx_q[idx_q];
  assign w_oy   = w_sort ? vy_q[0]      : vy_q[idx_q];
  assign w_ax   = w_sort ? vx_q[idx_q]  : vx_q[w_next];
  assign w_ay   = w_sort ? vy_q[idx_q]  : vy_q[w_next];
  assign w_bx   = w_sort ? vx_q[w_next] : px_q;
  assign w_by   = w_sort ? vy_q[w_next] : py_q;

  assign w_cross = cross2(sdiff(w_ax, w_ox), sdiff(w_ay, w_oy),
                          sdiff(w_bx, w_ox), sdiff(w_by, w_oy));
  assign w_neg   = w_cross[CW-1];
  assign w_zero  = (w_cross == '0);

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    any_neg_d  = any_neg_q;
    any_zero_d = any_zero_q;
    valid_d    = 1'b0;
    inside_d   = inside_q;
    onedge_d   = onedge_q;
    w_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_ready = 1'b1;
        if (in_valid) begin
          px_d    = X;
          py_d    = Y;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        w_ready = 1'b1;
        if (in_valid) begin
          vx_d[idx_q] = X;
          vy_d[idx_q] = Y;
          if (idx_q == LAST_V) begin
            idx_d   = IW'(1);
            pass_d  = '0;
            state_d = S_SORT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_SORT: begin
        // V[j+1] lies clockwise of V[j] about V0: swap. Ties keep order.
        if (w_neg) begin
          vx_d[idx_q]  = vx_q[w_next];
          vy_d[idx_q]  = vy_q[w_next];
          vx_d[w_next] = vx_q[idx_q];
          vy_d[w_next] = vy_q[idx_q];
        end
        if (idx_q == LAST_J) begin
          idx_d = IW'(1);
          if (pass_q == LAST_P) begin
            idx_d      = '0;
            any_neg_d  = 1'b0;
            any_zero_d = 1'b0;
            state_d    = S_CHECK;
          end else begin
            pass_d = pass_q + IW'(1);
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_CHECK: begin
        any_neg_d  = any_neg_q  | w_neg;
        any_zero_d = any_zero_q | w_zero;
        if (idx_q == LAST_V) begin
          // Results are registered here so they appear with valid in DONE.
          valid_d  = 1'b1;
          onedge_d = any_zero_d & ~any_neg_d;
          inside_d = ~any_neg_d & (INCLUDE_EDGE | ~any_zero_d);
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      for (int i = 0; i < N_VERT; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      idx_q      <= '0;
      pass_q     <= '0;
      any_neg_q  <= 1'b0;
      any_zero_q <= 1'b0;
      valid_q    <= 1'b0;
      inside_q   <= 1'b0;
      onedge_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      any_neg_q  <= any_neg_d;
      any_zero_q <= any_zero_d;
      valid_q    <= valid_d;
      inside_q   <= inside_d;
      onedge_q   <= onedge_d;
    end
  end

  // The state register sits in IDLE during reset; gating with reset keeps
  // in_ready low for as long as reset is held.
  assign in_ready  = w_ready & reset;
  assign valid     = valid_q;
  assign is_inside = inside_q;
  assign on_edge   = onedge_q;

endmodule
`default_nettype wire

// File: tb/tb_geofence_poly.sv
`default_nettype none
// ============================================================================
//  Module   : tb_geofence_poly
//  Purpose  : Self-checking bench for geofence_poly. Two 6-vertex instances
//             (edge excluded / edge included) share one input bus; a 3-vertex
//             instance has its own bus. Expected results come from a
//             hull-edge reference model on exact integer arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_geofence_poly;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         in_valid6;
  logic [W-1:0] x6, y6;
  logic         rdy_a, val_a, ins_a, on_a;
  logic         rdy_b, val_b, ins_b, on_b;

  logic         in_valid3;
  logic [W-1:0] x3, y3;
  logic         rdy_c, val_c, ins_c, on_c;

  geofence_poly #(.N_VERT(6), .W(W), .INCLUDE_EDGE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(rdy_a),
    .X(x6), .Y(y6), .valid(val_a), .is_inside(ins_a), .on_edge(on_a));

  geofence_poly #(.N_VERT(6), .W(W), .INCLUDE_EDGE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(rdy_b),
    .X(x6), .Y(y6), .valid(val_b), .is_inside(ins_b), .on_edge(on_b));

  geofence_poly #(.N_VERT(3), .W(W), .INCLUDE_EDGE(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(rdy_c),
    .X(x3), .Y(y3), .valid(val_c), .is_inside(ins_c), .on_edge(on_c));

  int     checks = 0;
  int     fails  = 0;

  // Current job
  longint jx [8];
  longint jy [8];
  longint jpx, jpy;
  int     jn;
  bit     jsel;          // 1 selects the 3-vertex instance

  // Model outputs
  bit     e_in0, e_in1, e_on;
  int     hull_edges;

  // Last reported results, for the hold check
  logic   prev_a, prev_b, prev_c;
  bit     pulse_pend;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint cr(longint ax, longint ay, longint bx, longint by);
    return ax * by - ay * bx;
  endfunction

  // Reference: a directed pair (i->j) is a counter-clockwise hull edge when
  // every other vertex lies strictly to its left. P is tested against those.
  function automatic void model();
    bit     neg, zer, is_e;
    longint e;
    neg = 0; zer = 0; hull_edges = 0;
    for (int i = 0; i < jn; i++) begin
      for (int j = 0; j < jn; j++) begin
        if (i != j) begin
          is_e = 1;
          for (int k = 0; k < jn; k++)
            if (k != i && k != j &&
                cr(jx[j]-jx[i], jy[j]-jy[i], jx[k]-jx[i], jy[k]-jy[i]) <= 0)
              is_e = 0;
          if (is_e) begin
            hull_edges++;
            e = cr(jx[j]-jx[i], jy[j]-jy[i], jpx-jx[i], jpy-jy[i]);
            if (e < 0)  neg = 1;
            if (e == 0) zer = 1;
          end
        end
      end
    end
    e_on  = zer & ~neg;
    e_in0 = ~neg & ~zer;
    e_in1 = ~neg;
  endfunction

  task automatic set_bus(input bit v, input longint x, input longint y);
    if (jsel) begin
      in_valid3 = v; x3 = x[W-1:0]; y3 = y[W-1:0];
    end else begin
      in_valid6 = v; x6 = x[W-1:0]; y6 = y[W-1:0];
    end
  endtask

  task automatic beat(input longint x, input longint y, input int gap);
    int t;
    @(negedge clk);
    if (pulse_pend) begin
      pulse_pend = 0;
      chk("valid_one_cycle", jsel ? val_c : val_a, 1'b0);
      chk("ready_after_done", jsel ? rdy_c : rdy_a, 1'b1);
    end
    for (int g = 0; g < gap; g++) begin
      set_bus(0, longint'($urandom), longint'($urandom));
      @(negedge clk);
    end
    t = 0;
    while (!(jsel ? rdy_c : rdy_a) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 1'b0, 1'b1);
    set_bus(1, x, y);
    @(posedge clk);
    #1;
    set_bus(0, x, y);
  endtask

  task automatic load_job(input int gaps);
    int gcnt [8];
    model();
    for (int i = 0; i < 8; i++) gcnt[i] = 0;
    for (int g = 0; g < gaps; g++) gcnt[$urandom_range(0, jn-1)]++;
    beat(jpx, jpy, 0);
    for (int i = 0; i < jn; i++) beat(jx[i], jy[i], gcnt[i]);
    if (jsel) chk("hold_inside_c", ins_c, prev_c);
    else begin
      chk("hold_inside_a", ins_a, prev_a);
      chk("hold_inside_b", ins_b, prev_b);
    end
  endtask

  task automatic finish_job(input bit junk);
    int lat;
    bit saw_rdy;
    lat = 0; saw_rdy = 0;
    while (lat < 200) begin
      if (junk) set_bus(1, longint'($urandom), longint'($urandom));
      @(negedge clk);
      lat++;
      if (jsel ? rdy_c : (rdy_a | rdy_b)) saw_rdy = 1;
      if (jsel ? val_c : val_a) break;
    end
    set_bus(0, 0, 0);
    chk("latency", lat, (jn-2)*(jn-2) + jn + 1);
    chk("ready_low_busy", saw_rdy, 1'b0);
    if (jsel) begin
      chk("inside_c", ins_c, e_in0);
      chk("on_edge_c", on_c, e_on);
      prev_c = ins_c;
    end else begin
      chk("valid_b", val_b, 1'b1);
      chk("inside_a", ins_a, e_in0);
      chk("on_edge_a", on_a, e_on);
      chk("inside_b", ins_b, e_in1);
      chk("on_edge_b", on_b, e_on);
      prev_a = ins_a;
      prev_b = ins_b;
    end
    pulse_pend = 1;
  endtask

  task automatic set_hex();
    jsel = 0; jn = 6;
    jx[0] = 450; jy[0] = 413;  jx[1] = 600; jy[1] = 500;
    jx[2] = 450; jy[2] = 587;  jx[3] = 550; jy[3] = 413;
    jx[4] = 400; jy[4] = 500;  jx[5] = 550; jy[5] = 587;
  endtask

  task automatic shuffle();
    int     r;
    longint t;
    for (int i = jn-1; i > 0; i--) begin
      r = $urandom_range(0, i);
      t = jx[i]; jx[i] = jx[r]; jx[r] = t;
      t = jy[i]; jy[i] = jy[r]; jy[r] = t;
    end
  endtask

  task automatic pick_point();
    if ($urandom_range(0, 3) == 0) begin
      int v;
      v = $urandom_range(0, jn-1);
      jpx = jx[v]; jpy = jy[v];
    end else begin
      jpx = $urandom_range(0, 1023);
      jpy = $urandom_range(0, 1023);
    end
  endtask

  task automatic gen_hex();
    real r, a;
    int  tries;
    jsel = 0; jn = 6; tries = 0;
    do begin
      r = real'($urandom_range(100, 511));
      for (int i = 0; i < jn; i++) begin
        a = real'($urandom_range(0, 35999)) * 3.14159265358979 / 18000.0;
        jx[i] = longint'($rtoi(512.0 + r * $cos(a)));
        jy[i] = longint'($rtoi(512.0 + r * $sin(a)));
      end
      jpx = 0; jpy = 0;
      model();
      tries++;
    end while (hull_edges != jn && tries < 1000);
    pick_point();
  endtask

  function automatic longint coord_full();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1023;
      default: return longint'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic gen_tri();
    int tries;
    jsel = 1; jn = 3; tries = 0;
    do begin
      for (int i = 0; i < jn; i++) begin
        jx[i] = coord_full();
        jy[i] = coord_full();
      end
      jpx = 0; jpy = 0;
      model();
      tries++;
    end while (hull_edges != jn && tries < 1000);
    pick_point();
  endtask

  initial begin
    bit saw;
    reset = 1'b0;
    in_valid6 = 0; x6 = '0; y6 = '0;
    in_valid3 = 0; x3 = '0; y3 = '0;
    prev_a = 0; prev_b = 0; prev_c = 0;
    pulse_pend = 0;
    jsel = 0; jn = 6;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", val_a, 1'b0);
    chk("rst_inside", ins_a, 1'b0);
    chk("rst_on_edge", on_a, 1'b0);
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_ready_c", rdy_c, 1'b0);
    reset = 1'b1;

    // Hexagon, interior point
    set_hex(); jpx = 500; jpy = 500;
    load_job(0); finish_job(0);
    chk("hex_in_inside", ins_a, 1'b1);
    chk("hex_in_on_edge", on_a, 1'b0);

    // Back-to-back: exterior point
    set_hex(); jpx = 700; jpy = 500;
    load_job(0); finish_job(0);
    chk("hex_out_inside", ins_a, 1'b0);
    chk("hex_out_on_edge", on_a, 1'b0);

    // Boundary point on (550,587)-(450,587)
    set_hex(); jpx = 500; jpy = 587;
    load_job(0); finish_job(0);
    chk("hex_edge_inside_excl", ins_a, 1'b0);
    chk("hex_edge_on_excl", on_a, 1'b1);
    chk("hex_edge_inside_incl", ins_b, 1'b1);
    chk("hex_edge_on_incl", on_b, 1'b1);

    // Reset in the middle of SORT
    set_hex(); jpx = 500; jpy = 500;
    load_job(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_valid", val_a, 1'b0);
    chk("abort_on_edge", on_a, 1'b0);
    chk("abort_inside_b", ins_b, 1'b0);
    chk("abort_ready", rdy_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (val_a | val_b) saw = 1;
    end
    chk("abort_no_pulse", saw, 1'b0);
    prev_a = 0; prev_b = 0; pulse_pend = 0;

    // Fresh job: shuffled hexagon with gaps and beats offered while busy
    set_hex(); shuffle(); jpx = 500; jpy = 500;
    load_job(3); finish_job(1);
    chk("fresh_inside", ins_a, 1'b1);

    // Full-scale triangle
    jsel = 1; jn = 3;
    jx[0] = 0;    jy[0] = 0;
    jx[1] = 0;    jy[1] = 1023;
    jx[2] = 1023; jy[2] = 0;
    jpx = 100; jpy = 100;
    load_job(0); finish_job(0);
    chk("tri_in", ins_c, 1'b1);
    jpx = 1023; jpy = 1023;
    load_job(0); finish_job(0);
    chk("tri_out", ins_c, 1'b0);

    // Randomised jobs
    for (int n = 0; n < 20; n++) begin
      gen_hex();
      load_job(($urandom_range(0, 1) == 1) ? 3 : 0);
      finish_job(1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 20; n++) begin
      gen_tri();
      load_job(($urandom_range(0, 1) == 1) ? 3 : 0);
      finish_job(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
